// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the CR access-port arbiter.
package rvc_asap_pkg;

    // Arbiter FSM states: core-priority operation and the one-cycle forced external grant
    typedef enum logic {
        ARB_CORE  = 1'b0,
        ARB_FORCE = 1'b1
    } t_cr_arb_state;

    // Which side issued the read whose data returns on the next cycle
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        EXT  = 2'd2
    } t_cr_rd_owner;

    localparam int unsigned CR_ARB_STARVE_LIMIT_DEF = 8;
    localparam int          CR_ARB_CNT_W            = 8;

    // Owner of a read issued this cycle; the core wins if both were flagged
    function automatic t_cr_rd_owner cr_rd_owner(input logic core_rd, input logic ext_rd);
        if (core_rd) begin
            return CORE;
        end else if (ext_rd) begin
            return EXT;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/rvc_asap_5pl_cr_arb_starve.sv
// Saturating starvation counter for the CR arbiter.
// near_o is high when the next increment brings the count to LIMIT, so the
// arbiter can schedule the forced grant for the following cycle.
module rvc_asap_5pl_cr_arb_starve
    import rvc_asap_pkg::*;
#(
    parameter int unsigned LIMIT = CR_ARB_STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic near_o
);

    localparam logic [CR_ARB_CNT_W-1:0] LIMIT_C = CR_ARB_CNT_W'(LIMIT);

    logic [CR_ARB_CNT_W-1:0] cnt_q;
    logic [CR_ARB_CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count holds once it reaches LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // LIMIT is at least 1, so LIMIT_C - 1 never underflows
    assign near_o = (cnt_q >= (LIMIT_C - 1'b1));

endmodule

// File: rtl/rvc_asap_5pl_cr_arb.sv
// Arbiter for the single CR memory port shared by the core memory stage and
// one external requester. Core has fixed priority. With RVC_CR_ARB_STARVE_EN
// defined, a starvation counter forces one external grant (stalling the core)
// after STARVE_LIMIT consecutive denied external-request cycles.
module rvc_asap_5pl_cr_arb
    import rvc_asap_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = CR_ARB_STARVE_LIMIT_DEF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        CoreWrEn,
    input  logic        CoreRdEn,
    input  logic [31:0] CoreAddr,
    input  logic [31:0] CoreWrData,
    output logic        CoreStall,
    output logic [31:0] CoreRdData,
    input  logic        ExtReq,
    input  logic        ExtWe,
    input  logic [31:0] ExtAddr,
    input  logic [31:0] ExtWrData,
    output logic        ExtGnt,
    output logic        ExtRdValid,
    output logic [31:0] ExtRdData,
    output logic        CtrlCRMemWrEn,
    output logic        SelCRMemWb,
    output logic [31:0] AluOut,
    output logic [31:0] RegRdData2,
    input  logic [31:0] CRMemRdDataQ104H
);

    logic         core_acc;
    logic         core_gnt;
    logic         ext_gnt;
    logic         core_stall;
    t_cr_rd_owner owner_q;
    t_cr_rd_owner owner_d;
    logic [31:0]  addr_q;
    logic [31:0]  addr_d;
    logic [31:0]  wdata_q;
    logic [31:0]  wdata_d;
    logic [31:0]  core_rd_q;
    logic [31:0]  ext_rd_q;
    logic         core_rd_sel;
    logic         ext_rd_sel;

    assign core_acc = CoreWrEn | CoreRdEn;

`ifdef RVC_CR_ARB_STARVE_EN
    t_cr_arb_state state_q;
    t_cr_arb_state state_d;
    logic          starve_inc;
    logic          starve_clr;
    logic          starve_near;

    rvc_asap_5pl_cr_arb_starve #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i  (Clock),
        .rst_i  (Rst),
        .inc_i  (starve_inc),
        .clr_i  (starve_clr),
        .near_o (starve_near)
    );

    // Grant decision, starvation counting and next state
    always_comb begin
        core_gnt   = 1'b0;
        ext_gnt    = 1'b0;
        core_stall = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        state_d    = state_q;
        if (Rst) begin
            starve_clr = 1'b1;
            state_d    = ARB_CORE;
        end else begin
            case (state_q)
                ARB_CORE: begin
                    if (core_acc) begin
                        core_gnt = 1'b1;
                        if (ExtReq) begin
                            starve_inc = 1'b1;
                            if (starve_near) begin
                                state_d = ARB_FORCE;
                            end
                        end else begin
                            starve_clr = 1'b1;
                        end
                    end else begin
                        ext_gnt    = ExtReq;
                        starve_clr = 1'b1;
                    end
                end
                ARB_FORCE: begin
                    // A dropped request here issues nothing and leaves the core unstalled
                    starve_clr = 1'b1;
                    state_d    = ARB_CORE;
                    if (ExtReq) begin
                        ext_gnt    = 1'b1;
                        core_stall = 1'b1;
                    end
                end
                default: begin
                    starve_clr = 1'b1;
                    state_d    = ARB_CORE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q <= ARB_CORE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic unused_starve_limit;

    // Pure core priority: external side only gets core-idle cycles
    always_comb begin
        core_gnt   = !Rst && core_acc;
        ext_gnt    = !Rst && !core_acc && ExtReq;
        core_stall = 1'b0;
    end

    assign unused_starve_limit = |STARVE_LIMIT;
`endif

    assign ExtGnt    = ext_gnt;
    assign CoreStall = core_stall;

    // CR port mux; address and data hold their last values when idle
    always_comb begin
        CtrlCRMemWrEn = 1'b0;
        SelCRMemWb    = 1'b0;
        AluOut        = addr_q;
        RegRdData2    = wdata_q;
        if (core_gnt) begin
            CtrlCRMemWrEn = CoreWrEn;
            SelCRMemWb    = CoreRdEn;
            AluOut        = CoreAddr;
            RegRdData2    = CoreWrData;
        end else if (ext_gnt) begin
            CtrlCRMemWrEn = ExtWe;
            SelCRMemWb    = !ExtWe;
            AluOut        = ExtAddr;
            RegRdData2    = ExtWrData;
        end
    end

    assign addr_d  = AluOut;
    assign wdata_d = RegRdData2;
    assign owner_d = cr_rd_owner(core_gnt && CoreRdEn, ext_gnt && !ExtWe);

    // Read ownership and port hold registers; reset drops any in-flight read
    always_ff @(posedge Clock) begin
        if (Rst) begin
            owner_q   <= NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            core_rd_q <= '0;
            ext_rd_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            core_rd_q <= CoreRdData;
            ext_rd_q  <= ExtRdData;
        end
    end

    assign core_rd_sel = !Rst && (owner_q == CORE);
    assign ext_rd_sel  = !Rst && (owner_q == EXT);
    assign CoreRdData  = core_rd_sel ? CRMemRdDataQ104H : core_rd_q;
    assign ExtRdData   = ext_rd_sel ? CRMemRdDataQ104H : ext_rd_q;
    assign ExtRdValid  = ext_rd_sel;

    // The core never loads and stores CR space in the same cycle
    assert property (@(posedge Clock) disable iff (Rst) !(CoreWrEn && CoreRdEn));

endmodule

// File: tb/tb_rvc_asap_5pl_cr_arb.sv
// Bench for the CR port arbiter: directed scenarios followed by random
// traffic, checked against a cycle-level behavioural model with a shadow
// copy of the CR memory.
module tb_rvc_asap_5pl_cr_arb;

    localparam int          TB_LIMIT  = 3;
    localparam logic [31:0] CR_LED    = 32'h0000_0000;
    localparam logic [31:0] CR_SEG7_0 = 32'h0000_0008;
    localparam logic [31:0] CR_SWITCH = 32'h0000_0024;
`ifdef RVC_CR_ARB_STARVE_EN
    localparam int EXP_GNT_AT = 4;
    localparam int EXP_STALLS = 1;
`else
    localparam int EXP_GNT_AT = 0;
    localparam int EXP_STALLS = 0;
`endif

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic        CoreWrEn = 1'b0;
    logic        CoreRdEn = 1'b0;
    logic [31:0] CoreAddr = '0;
    logic [31:0] CoreWrData = '0;
    logic        CoreStall;
    logic [31:0] CoreRdData;
    logic        ExtReq = 1'b0;
    logic        ExtWe = 1'b0;
    logic [31:0] ExtAddr = '0;
    logic [31:0] ExtWrData = '0;
    logic        ExtGnt;
    logic        ExtRdValid;
    logic [31:0] ExtRdData;
    logic        CtrlCRMemWrEn;
    logic        SelCRMemWb;
    logic [31:0] AluOut;
    logic [31:0] RegRdData2;
    logic [31:0] CRMemRdDataQ104H;

    int total = 0;
    int bad = 0;

    // shadow stimulus, applied to the DUT at the start of each cycle
    logic        s_cwe = 1'b0, s_crd = 1'b0, s_ereq = 1'b0, s_ewe = 1'b0;
    logic [31:0] s_caddr = '0, s_cwd = '0, s_eaddr = '0, s_ewd = '0;

    // reference model state
    int          m_wait = 0;
    bit          m_force = 1'b0;
    int          m_owner = 0;          // 0 none, 1 core, 2 ext
    logic [31:0] m_val = '0;
    logic [31:0] m_core_rd = '0;
    logic [31:0] m_ext_rd = '0;
    bit          m_last_eg = 1'b0;
    bit          m_last_stall = 1'b0;
    logic [31:0] ref_mem [16];

    // CR memory environment
    logic        mem_init = 1'b1;
    logic [31:0] crmem [16];

    rvc_asap_5pl_cr_arb #(
        .STARVE_LIMIT (TB_LIMIT)
    ) dut (
        .Clock            (Clock),
        .Rst              (Rst),
        .CoreWrEn         (CoreWrEn),
        .CoreRdEn         (CoreRdEn),
        .CoreAddr         (CoreAddr),
        .CoreWrData       (CoreWrData),
        .CoreStall        (CoreStall),
        .CoreRdData       (CoreRdData),
        .ExtReq           (ExtReq),
        .ExtWe            (ExtWe),
        .ExtAddr          (ExtAddr),
        .ExtWrData        (ExtWrData),
        .ExtGnt           (ExtGnt),
        .ExtRdValid       (ExtRdValid),
        .ExtRdData        (ExtRdData),
        .CtrlCRMemWrEn    (CtrlCRMemWrEn),
        .SelCRMemWb       (SelCRMemWb),
        .AluOut           (AluOut),
        .RegRdData2       (RegRdData2),
        .CRMemRdDataQ104H (CRMemRdDataQ104H)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h0000_02A5;
        if (i == 9) return 32'h0000_0155;
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    always @(posedge Clock) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) crmem[i] <= init_word(i);
        end else if (CtrlCRMemWrEn) begin
            crmem[AluOut[5:2]] <= RegRdData2;
        end
        CRMemRdDataQ104H <= crmem[AluOut[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply shadow inputs, check against the model, advance the model
    task automatic cycle();
        logic        acc, x_cg, x_eg, x_st, x_wr, x_sel;
        logic [31:0] x_addr, x_data;
        int          new_owner;
        @(negedge Clock);
        CoreWrEn = s_cwe; CoreRdEn = s_crd; CoreAddr = s_caddr; CoreWrData = s_cwd;
        ExtReq = s_ereq; ExtWe = s_ewe; ExtAddr = s_eaddr; ExtWrData = s_ewd;
        #1;
        acc = s_cwe | s_crd;
        x_cg = 1'b0; x_eg = 1'b0; x_st = 1'b0;
`ifdef RVC_CR_ARB_STARVE_EN
        if (m_force) begin
            x_eg = s_ereq;
            x_st = s_ereq;
        end else if (acc) begin
            x_cg = 1'b1;
        end else begin
            x_eg = s_ereq;
        end
`else
        if (acc) x_cg = 1'b1;
        else x_eg = s_ereq;
`endif
        x_wr = 1'b0; x_sel = 1'b0; x_addr = '0; x_data = '0; new_owner = 0;
        if (x_cg) begin
            x_wr = s_cwe; x_sel = s_crd; x_addr = s_caddr; x_data = s_cwd;
            new_owner = s_crd ? 1 : 0;
        end else if (x_eg) begin
            x_wr = s_ewe; x_sel = !s_ewe; x_addr = s_eaddr; x_data = s_ewd;
            new_owner = s_ewe ? 0 : 2;
        end
        // read data returned for the previous cycle's owner
        if (m_owner == 1) m_core_rd = m_val;
        if (m_owner == 2) m_ext_rd = m_val;
        chk("ext_gnt", 32'(ExtGnt), 32'(x_eg));
        chk("core_stall", 32'(CoreStall), 32'(x_st));
        chk("cr_wr_en", 32'(CtrlCRMemWrEn), 32'(x_wr));
        chk("cr_rd_sel", 32'(SelCRMemWb), 32'(x_sel));
        if (x_cg || x_eg) begin
            chk("cr_addr", AluOut, x_addr);
            chk("cr_wdata", RegRdData2, x_data);
        end
        chk("core_rd_data", CoreRdData, m_core_rd);
        chk("ext_rd_valid", 32'(ExtRdValid), 32'(m_owner == 2));
        chk("ext_rd_data", ExtRdData, m_ext_rd);
        // advance model to the next cycle
        m_owner = new_owner;
        m_val = ref_mem[x_addr[5:2]];
        if ((x_cg || x_eg) && x_wr) ref_mem[x_addr[5:2]] = x_data;
`ifdef RVC_CR_ARB_STARVE_EN
        if (m_force) begin
            m_force = 1'b0;
            m_wait = 0;
        end else if (acc && s_ereq) begin
            m_wait++;
            if (m_wait >= TB_LIMIT) m_force = 1'b1;
        end else begin
            m_wait = 0;
        end
`endif
        m_last_eg = x_eg;
        m_last_stall = x_st;
    endtask

    // Reset for one clock with idle inputs; check outputs during and after reset
    task automatic reset_dut();
        @(negedge Clock);
        Rst = 1'b1;
        CoreWrEn = 1'b0; CoreRdEn = 1'b0; ExtReq = 1'b0; ExtWe = 1'b0;
        #1;
        chk("rst_ext_rd_valid", 32'(ExtRdValid), 32'd0);
        chk("rst_ext_gnt", 32'(ExtGnt), 32'd0);
        chk("rst_core_stall", 32'(CoreStall), 32'd0);
        chk("rst_wr_en", 32'(CtrlCRMemWrEn), 32'd0);
        chk("rst_rd_sel", 32'(SelCRMemWb), 32'd0);
        @(negedge Clock);
        Rst = 1'b0;
        mem_init = 1'b0;
        #1;
        chk("rst_core_rd_data", CoreRdData, 32'd0);
        chk("rst_ext_rd_data", ExtRdData, 32'd0);
        chk("rst_ext_rd_valid_after", 32'(ExtRdValid), 32'd0);
        chk("rst_ext_gnt_after", 32'(ExtGnt), 32'd0);
        m_wait = 0; m_force = 1'b0; m_owner = 0; m_val = '0;
        m_core_rd = '0; m_ext_rd = '0; m_last_eg = 1'b0; m_last_stall = 1'b0;
        s_cwe = 1'b0; s_crd = 1'b0; s_ereq = 1'b0; s_ewe = 1'b0;
    endtask

    initial begin
        int gnt_at;
        int stall_cnt;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // power-on reset
        reset_dut();

        // core reads LED, external idle
        s_crd = 1'b1; s_caddr = CR_LED;
        cycle();
        s_crd = 1'b0;
        cycle();
        chk("tp_core_rd_led", CoreRdData, 32'h0000_02A5);
        chk("tp_no_ext_valid", 32'(ExtRdValid), 32'd0);

        // external write to SEG7_0 while core idle
        s_ereq = 1'b1; s_ewe = 1'b1; s_eaddr = CR_SEG7_0; s_ewd = 32'h7F;
        cycle();
        chk("tp_ext_wr_gnt", 32'(ExtGnt), 32'd1);
        chk("tp_ext_wr_en", 32'(CtrlCRMemWrEn), 32'd1);
        chk("tp_ext_wr_addr", AluOut, CR_SEG7_0);
        s_ereq = 1'b0; s_ewe = 1'b0;

        // core read in N, external read of Switch in N+1
        s_crd = 1'b1; s_caddr = CR_SEG7_0;
        cycle();
        s_crd = 1'b0; s_ereq = 1'b1; s_ewe = 1'b0; s_eaddr = CR_SWITCH;
        cycle();
        chk("tp_core_rd_seg7", CoreRdData, 32'h7F);
        s_ereq = 1'b0;
        cycle();
        chk("tp_ext_rd_valid", 32'(ExtRdValid), 32'd1);
        chk("tp_ext_rd_switch", ExtRdData, 32'h0000_0155);

        // continuous core stores with a pending external write
        s_ereq = 1'b1; s_ewe = 1'b1; s_eaddr = CR_SEG7_0; s_ewd = 32'h11;
        s_cwe = 1'b1;
        gnt_at = 0;
        stall_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            if (!m_last_stall) begin
                s_caddr = 32'(k) << 2;
                s_cwd = 32'hA000 + 32'(k);
            end
            cycle();
            if (ExtGnt === 1'b1 && gnt_at == 0) gnt_at = k;
            if (CoreStall === 1'b1) stall_cnt++;
            if (m_last_eg) s_ereq = 1'b0;
        end
        chk("starve_gnt_cycle", 32'(gnt_at), 32'(EXP_GNT_AT));
        chk("starve_stall_count", 32'(stall_cnt), 32'(EXP_STALLS));
        s_cwe = 1'b0;
        cycle();
        s_ereq = 1'b0;

        // external read granted, reset the following cycle
        s_ereq = 1'b1; s_ewe = 1'b0; s_eaddr = CR_SWITCH;
        cycle();
        chk("rstrd_ext_gnt", 32'(ExtGnt), 32'd1);
        reset_dut();

        // pending forced grant is cancelled by reset
        s_ereq = 1'b1; s_ewe = 1'b1; s_eaddr = CR_LED; s_ewd = 32'h2A5; s_cwe = 1'b1;
        for (int k = 0; k < TB_LIMIT; k++) begin
            s_caddr = 32'(k + 10) << 2;
            cycle();
        end
        reset_dut();
        s_ereq = 1'b1; s_ewe = 1'b1; s_eaddr = CR_LED; s_ewd = 32'h2A5;
        s_cwe = 1'b1; s_caddr = 32'h30;
        cycle();
        chk("cancel_no_ext_gnt", 32'(ExtGnt), 32'd0);
        chk("cancel_no_stall", 32'(CoreStall), 32'd0);
        s_cwe = 1'b0;
        cycle();
        s_ereq = 1'b0;

        // random traffic honouring hold-until-granted and hold-while-stalled
        for (int n = 0; n < 400; n++) begin
            if (!m_last_stall) begin
                case ($urandom_range(0, 3))
                    0:       begin s_cwe = 1'b0; s_crd = 1'b0; end
                    1:       begin s_cwe = 1'b0; s_crd = 1'b1; end
                    default: begin s_cwe = 1'b1; s_crd = 1'b0; end
                endcase
                s_caddr = 32'($urandom_range(0, 15)) << 2;
                s_cwd = $urandom;
            end
            if (!(s_ereq && !m_last_eg)) begin
                s_ereq = ($urandom_range(0, 2) != 0);
                s_ewe = 1'($urandom_range(0, 1));
                s_eaddr = 32'($urandom_range(0, 15)) << 2;
                s_ewd = $urandom;
            end
            cycle();
        end

        // drain outstanding reads
        s_cwe = 1'b0; s_crd = 1'b0; s_ereq = 1'b0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvc_asap_5pl_cr_arb.md
# rvc_asap_5pl_cr_arb

Arbiter sharing the single CR memory access port between the core pipeline (memory stage) and one external requester (debug/loader/display engine). It sits between the core and `rvc_asap_5pl_cr_mem` and drives that block's write-enable, read-select, address and write-data inputs. It also routes the registered read data back to whichever side issued the read. The core has fixed priority; a starvation guard can force the external side through by stalling the core for one cycle.

## Interface
- `STARVE_LIMIT`, default 8: consecutive denied external-request cycles before a forced grant; legal range 1..255.
- `Clock` in 1: single clock; every flop updates on the rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `CoreWrEn` in 1: core store to CR space.
- `CoreRdEn` in 1: core load from CR space.
- `CoreAddr` in 32: core CR offset.
- `CoreWrData` in 32: core store data.
- `CoreStall` out 1: core must hold its memory stage this cycle.
- `CoreRdData` out 32: load data for the core.
- `ExtReq` in 1: external access request; held until granted.
- `ExtWe` in 1: 1 = write, 0 = read; held with `ExtReq`.
- `ExtAddr` in 32: external CR offset.
- `ExtWrData` in 32: external write data.
- `ExtGnt` out 1: access performed this cycle.
- `ExtRdValid` out 1: `ExtRdData` is valid.
- `ExtRdData` out 32: external read data.
- `CtrlCRMemWrEn` out 1: to CR memory.
- `SelCRMemWb` out 1: to CR memory.
- `AluOut` out 32: offset to CR memory.
- `RegRdData2` out 32: write data to CR memory.
- `CRMemRdDataQ104H` in 32: CR memory read data, valid one cycle after the read access.

## Operation
- Core access means `CoreWrEn | CoreRdEn`. Core write and read in the same cycle is illegal; the block asserts on it in simulation.
- FSM states are `ARB_CORE`, `ARB_FORCE`, and reset state `ARB_CORE`.
- In `ARB_CORE`:
  - If there is a core access, the core signals pass to the CR port, `ExtGnt` = 0, and the starvation counter increments if `ExtReq` is high.
  - If there is no core access and `ExtReq` is high, the external signals pass through, `ExtGnt` = 1, and the counter clears.
  - If `ExtReq` is low, the counter clears.
  - When the counter reaches `STARVE_LIMIT` with `ExtReq` still high, the next state is `ARB_FORCE`.
- In `ARB_FORCE`:
  - External access passes through, `ExtGnt` = 1, `CoreStall` = 1, the core port is blocked, and the counter clears.
  - The next state is always `ARB_CORE`.
  - If `ExtReq` has dropped (protocol violation), no access is issued, `CoreStall` stays 0, and the FSM returns to `ARB_CORE`.
- Idle port: when no side is granted, `CtrlCRMemWrEn` = 0 and `SelCRMemWb` = 0. `AluOut` and `RegRdData2` keep their values, which are don't-care.
- Read ownership:
  - A 2-bit owner register (NONE/CORE/EXT) samples who issued a read each cycle.
  - Next cycle, owner CORE: `CoreRdData` = `CRMemRdDataQ104H`.
  - Next cycle, owner EXT: `ExtRdData` = `CRMemRdDataQ104H` and `ExtRdValid` = 1.
  - The non-owning read output holds its last value.
- A write never sets the owner (owner = NONE).
- Counter is 8 bits and saturates at `STARVE_LIMIT`; it never wraps.

## Timing
- `ExtGnt` and `CoreStall` are combinational from the current inputs and state, in the same cycle.
- Read latency is 1 cycle from grant to `CoreRdData` / `ExtRdValid`.
- Back-to-back reads from alternating owners are supported every cycle.
- Worst-case external wait under continuous core traffic is `STARVE_LIMIT` + 1 cycles.
- Reset values:
  - State = `ARB_CORE`, counter = 0, owner = NONE.
  - `ExtRdValid` = 0, `CoreRdData` = 0, `ExtRdData` = 0.
  - `CoreStall` = 0, `ExtGnt` = 0, `CtrlCRMemWrEn` = 0, `SelCRMemWb` = 0.
- `Rst` mid-operation: an in-flight read is dropped and no `ExtRdValid` follows. A pending `ARB_FORCE` is cancelled.
- During the forced cycle the core holds all its inputs stable; its access completes the following cycle.

## Configuration
- `RVC_CR_ARB_STARVE_EN` defined: starvation counter, `ARB_FORCE` state and `CoreStall` behave as above.
- Macro undefined:
  - Pure core priority; external access only in core-idle cycles.
  - `CoreStall` is tied 0.
  - Counter and `ARB_FORCE` are not built; `STARVE_LIMIT` is ignored.

## Structure
- `rvc_asap_pkg` holds:
  - `t_cr_arb_state` enum (`ARB_CORE`, `ARB_FORCE`).
  - `t_cr_rd_owner` enum (NONE, CORE, EXT).
  - Constant `CR_ARB_STARVE_LIMIT_DEF` = 8.
- One sub-module, `rvc_asap_5pl_cr_arb_starve`: saturating counter with increment/clear inputs and a limit-reached output. It is instantiated only under `RVC_CR_ARB_STARVE_EN`.

## Test plan
- Core reads `CR_LED` (LED = 0x2A5), `ExtReq` low → next cycle `CoreRdData` = 0x2A5, `ExtRdValid` = 0.
- Core idle, ext writes 0x7F to `CR_SEG7_0` → `ExtGnt` = 1 same cycle, `CtrlCRMemWrEn` = 1, `AluOut` = `CR_SEG7_0`.
- Core read in cycle N, ext read of `CR_Switch` (Switch = 0x155) in N+1 → `CoreRdData` valid at N+1, `ExtRdData` = 0x155 with `ExtRdValid` at N+2.
- Macro on, `STARVE_LIMIT` = 3, continuous core stores with `ExtReq` high → `ExtGnt` + `CoreStall` in 4th cycle, core store completes the next cycle.
- Macro off, same stimulus → `ExtGnt` never asserts while the core is busy, `CoreStall` always 0.
- Ext read granted, `Rst` asserted next cycle → `ExtRdValid` = 0, all outputs at reset values, state `ARB_CORE`.
